// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte-addressable little-endian data memory with a fixed
// number of wait states, sign/zero extension of loads and misalignment rejection.
module mem_stage #(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic [4:0]  destIn,
  output logic [31:0] res,
  output logic [31:0] data,
  output logic        regWrite,
  output logic        memToReg,
  output logic [4:0]  dest,
  output logic        stall,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

  // Handshake: stall=1 freezes upstream, which must hold every input steady;
  // the MEM/WB register captures this stage's outputs only in cycles with stall=0.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic [31:0] mem_q [DEPTH];

  logic                  req;
  logic                  misaligned;
  logic                  start;
  logic                  complete;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [31:0]           load_ext;
  logic [3:0]            be;
  logic [31:0]           wdata;

  assign widx  = addr[DEPTH_LOG2+1:2];
  assign rword = mem_q[widx];
  assign req   = memRead | memWrite;

  always_comb begin
    misaligned = 1'b0;
    if (size == 2'b01) misaligned = addr[0];
    else if (size[1])  misaligned = (addr[1:0] != 2'b00);
  end

  assign start    = (state_q == IDLE) && req && !misaligned;
  assign complete = (start && (WAIT_CYCLES == 0)) ||
                    ((state_q == BUSY) && (cnt_q == 4'd1));
  // An access aborted by reset must never reach the array.
  assign wr_en    = complete && memWrite && !rst;

  // Load lane selection and extension; word loads ignore unsignedLoad.
  always_comb begin
    rbyte    = rword[{addr[1:0], 3'b000} +: 8];
    rhalf    = addr[1] ? rword[31:16] : rword[15:0];
    load_ext = rword;
    case (size)
      2'b00:   load_ext = unsignedLoad ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_ext = unsignedLoad ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_ext = rword;
    endcase
  end

  // Store lanes are replicated from the low bits of storeData; be picks the bytes.
  always_comb begin
    be    = 4'b1111;
    wdata = storeData;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{storeData[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{storeData[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = storeData;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A store completes with a cleared load register so DONE shows data=0.
    if (complete) load_d = memWrite ? 32'd0 : load_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      load_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  // Memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    res      = addr;
    dest     = destIn;
    memToReg = memToRegIn;
    regWrite = regWriteIn;
    data     = 32'd0;
    stall    = 1'b0;
    misalign = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req && misaligned) begin
            misalign = 1'b1;
            regWrite = 1'b0;
          end else if (req) begin
            stall = 1'b1;
          end
        end
        BUSY:    stall = 1'b1;
        DONE:    data  = load_q;
        default: data  = 32'd0;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1, extra memory wait states per access (legal range 0..15).
REQ-002 SHALL provide parameter DEPTH_LOG2, default 8, log2 of data-memory depth in 32-bit words.
REQ-003 SHALL provide clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide memRead, memWrite  input  1 each  load and store requests from the EX/MEM register.
REQ-006 SHALL provide size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL provide unsignedLoad  input  1  1 means zero-extend loads; 0 means sign-extend.
REQ-008 SHALL provide addr  input  32  ALU result and byte address; storeData  input  32  store value.
REQ-009 SHALL provide regWriteIn, memToRegIn  input  1 each, and destIn  input  5: writeback controls.
REQ-010 SHALL provide res  output  32  addr passed through; data  output  32  extended load data.
REQ-011 SHALL provide regWrite, memToReg  output  1 each, and dest  output  5: controls for the MEM/WB register.
REQ-012 SHALL provide stall  output  1  freeze request to PC, IF/ID, ID/EX, EX/MEM; MEM/WB captures only when stall=0.
REQ-013 SHALL provide misalign  output  1  pulse flagging a rejected misaligned access.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 Non-memory instruction in IDLE: zero latency; res=addr; data=0; controls pass through; stall=0.
REQ-016 Misaligned request (half with addr[0]=1; word with addr[1:0]!=0) in IDLE: no memory access; misalign=1 and regWrite=0 that cycle; stall=0; FSM stays IDLE.
REQ-017 Aligned request in IDLE SHALL assert stall combinationally in the same cycle.
REQ-018 If WAIT_CYCLES=0, the access SHALL complete at that edge and the FSM SHALL go to DONE.
REQ-019 If WAIT_CYCLES>0, the wait counter SHALL load WAIT_CYCLES and the FSM SHALL go to BUSY.
REQ-020 BUSY SHALL hold stall=1 and decrement the counter each cycle; at counter=1 the access SHALL complete at that edge and the FSM SHALL go to DONE.
REQ-021 Total stall cycles per aligned access SHALL be exactly WAIT_CYCLES+1.
REQ-022 DONE SHALL hold stall=0, drive data from the load register and pass controls through, then return to IDLE unconditionally; inputs still showing a request in DONE SHALL NOT retrigger.
REQ-023 Memory SHALL be DEPTH_LOG2-bit word-indexed by addr[DEPTH_LOG2+1:2]; higher address bits ignored (wrap modulo size).
REQ-024 Memory SHALL be little-endian: stores use byte enables from size and addr[1:0], storeData lanes taken from its low bits, untouched bytes preserved.
REQ-025 Loads SHALL select the byte or half lane via addr[1:0] and extend to 32 bits per unsignedLoad.
REQ-026 Word loads SHALL ignore unsignedLoad.
REQ-027 memRead and memWrite both high SHALL be treated as a store.
REQ-028 Upstream SHALL hold all inputs stable while stall=1; the block SHALL NOT latch request inputs other than into its load register.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, counter=0 and load register=0, including when asserted mid-access; the aborted access SHALL NOT write memory.
REQ-030 During and after reset, stall=0 and misalign=0; other outputs follow REQ-015 for the current inputs.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 Word store then load, WAIT_CYCLES=1: sw 0xDEADBEEF@0x10, then lw @0x10 -> each access has 2 stall cycles; DONE data=0xDEADBEEF, regWrite=1.
REQ-033 Byte/half extension: sb 0x80@0x21, then lb -> data 0xFFFFFF80; lbu -> 0x00000080; sh 0x8001@0x22, then lh -> 0xFFFF8001.
REQ-034 Partial-store preservation: sw 0x11223344@0x30, sb 0xAA@0x32, then lw -> 0x11AA3344.
REQ-035 Misaligned request: lw @0x13 -> misalign=1, regWrite=0, stall=0 for one cycle; memory unchanged.
REQ-036 Reset mid-access: WAIT_CYCLES=3, sw 0x55@0x40 with rst pulsed in the 2nd BUSY cycle -> FSM IDLE, stall=0 next cycle; later lw @0x40 returns prior contents.
REQ-037 Back-to-back and wrap: WAIT_CYCLES=0, lw@0x0 then lw@0x400 with DEPTH_LOG2=8 -> one stall cycle each, no retrigger in DONE, both return word 0.
